// File: rtl/rr_grant_arbiter.sv
// Round-robin / fixed-priority arbiter with a one-hot registered grant and a
// selectable hold policy (NONE, REQUEST or ACKNOWLEDGE).
`timescale 1ns/1ps

module rr_grant_arbiter #(
    parameter int unsigned PORTS                = 8,
    parameter bit          ARB_TYPE_ROUND_ROBIN = 1'b1,
    parameter bit          LSB_HIGH_PRIORITY    = 1'b1,
    parameter string       BLOCK                = "ACKNOWLEDGE"
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded
);

    localparam int unsigned IW = $clog2(PORTS);
    localparam bit BLOCK_NONE = (BLOCK == "NONE");
    localparam bit BLOCK_REQ  = (BLOCK == "REQUEST");

    // Pointer sits one step before the top-priority port so that port wins first.
    localparam logic [IW-1:0] PTR_RESET = LSB_HIGH_PRIORITY ? IW'(PORTS - 1) : '0;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PORTS-1:0] grant_next;
    logic [IW-1:0]   enc_next;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_next;

    logic            any_found;
    logic [IW-1:0]   any_idx;
    logic            masked_found;
    logic [IW-1:0]   masked_idx;
    logic [IW-1:0]   pick;
    logic            rel;

    // Scan requests in priority order; the masked pick only accepts ports
    // strictly past the pointer, the plain pick is the wrap-around fallback.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        any_found    = 1'b0;
        any_idx      = '0;
        masked_found = 1'b0;
        masked_idx   = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            idx = LSB_HIGH_PRIORITY ? i : (PORTS - 1 - i);
            if (request[IW'(idx)]) begin
                if (!any_found) begin
                    any_found = 1'b1;
                    any_idx   = IW'(idx);
                end
                if (!masked_found &&
                    (LSB_HIGH_PRIORITY ? (idx > 32'(ptr)) : (idx < 32'(ptr)))) begin
                    masked_found = 1'b1;
                    masked_idx   = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        pick = any_idx;
        if (ARB_TYPE_ROUND_ROBIN && masked_found) begin
            pick = masked_idx;
        end
    end

    always_comb begin
        rel = 1'b0;
        if (state == GRANTED) begin
            if (BLOCK_NONE) begin
                rel = 1'b1;
            end else if (BLOCK_REQ) begin
                rel = !request[grant_encoded];
            end else begin
                rel = acknowledge[grant_encoded];
            end
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        enc_next   = grant_encoded;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (any_found) begin
                    state_next       = GRANTED;
                    grant_next       = '0;
                    grant_next[pick] = 1'b1;
                    enc_next         = pick;
                    ptr_next         = pick;
                end
            end
            GRANTED: begin
                // Release and re-arbitrate on the same edge for back-to-back grants.
                if (rel) begin
                    if (any_found) begin
                        grant_next       = '0;
                        grant_next[pick] = 1'b1;
                        enc_next         = pick;
                        ptr_next         = pick;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                        enc_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                enc_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            grant_encoded <= '0;
            ptr           <= PTR_RESET;
        end else begin
            state         <= state_next;
            grant         <= grant_next;
            grant_encoded <= enc_next;
            ptr           <= ptr_next;
        end
    end

    assign grant_valid = (state == GRANTED);

endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 The block SHALL have parameter PORTS, default 8, giving the number of requesters (2..32).
REQ-002 The block SHALL have parameter ARB_TYPE_ROUND_ROBIN, default 1: 1 = round-robin, 0 = fixed priority.
REQ-003 The block SHALL have parameter LSB_HIGH_PRIORITY, default 1: 1 = lowest index wins ties and defines the round-robin scan direction, 0 = highest index.
REQ-004 The block SHALL have parameter BLOCK, default "ACKNOWLEDGE", with values "NONE", "REQUEST" or "ACKNOWLEDGE"; this is the grant hold policy.
REQ-005 The block SHALL have port clk, input, width 1: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-007 The block SHALL have port request, input, width PORTS: per-port request, level.
REQ-008 The block SHALL have port acknowledge, input, width PORTS: per-port release strobe, meaningful only for the granted port.
REQ-009 The block SHALL have port grant, output, width PORTS: one-hot registered grant.
REQ-010 The block SHALL have port grant_valid, output, width 1: high when grant is non-zero.
REQ-011 The block SHALL have port grant_encoded, output, width $clog2(PORTS): binary index of the granted port, 0 when not valid.

Function
REQ-012 grant SHALL be zero or one-hot at every clock edge, and grant_encoded and grant_valid SHALL always be consistent with it.
REQ-013 The FSM SHALL have two states: IDLE (no grant) and GRANTED (grant held).
REQ-014 IDLE with request != 0 SHALL cause the FSM to enter GRANTED, with grant registered at the next edge (1-cycle latency from request to grant).
REQ-015 IDLE with request == 0 SHALL hold all outputs at zero.
REQ-016 Fixed priority SHALL select the lowest set index when LSB_HIGH_PRIORITY=1, else the highest set index.
REQ-017 Round-robin SHALL keep a mask pointer equal to the last granted index.
- Candidates strictly after the pointer in the scan direction win first.
- If there is no masked candidate, the scan wraps to the unmasked priority pick.
REQ-018 The pointer SHALL update only on the edge where a new grant is registered.
REQ-019 With BLOCK="ACKNOWLEDGE", the grant SHALL be held until acknowledge[grant_encoded]=1 is sampled, independent of request.
REQ-020 With BLOCK="REQUEST", the grant SHALL be held while request[grant_encoded]=1; it is released on the edge sampling it low.
REQ-021 With BLOCK="NONE", the block SHALL re-arbitrate every cycle; the grant follows request with 1-cycle latency.
REQ-022 On the release edge, the block SHALL re-arbitrate over the current request vector in the same cycle.
- If any request is set, the next grant is registered on that edge (back-to-back, no idle cycle), using the pointer already advanced past the released port.
- If none is set, the FSM returns to IDLE and grant becomes 0.
REQ-023 acknowledge bits for non-granted ports SHALL be ignored, as SHALL acknowledge while in IDLE.
REQ-024 Under round-robin, a port that has just released SHALL be re-granted immediately only if it is the sole requester.

Reset
REQ-025 rst_n low SHALL asynchronously force grant=0, grant_valid=0, grant_encoded=0, state=IDLE and the pointer to the highest-priority-minus-one position, so that port 0 (LSB_HIGH_PRIORITY=1) wins first after reset.
REQ-026 Reset asserted while in GRANTED SHALL drop the grant immediately without requiring acknowledge.
REQ-027 After rst_n deasserts, arbitration SHALL resume on the first rising clk edge.

Verification
REQ-028 A bench SHALL cover: PORTS=8 round-robin ACKNOWLEDGE; request=8'b00000001 -> one edge later grant=8'b00000001, grant_encoded=0, grant_valid=1; grant held for 5 cycles without ack.
REQ-029 A bench SHALL cover: request=8'b10010010 held, ack pulsed each grant -> grant sequence ports 1, 4, 7, 1, back-to-back with no idle cycle between grants.
REQ-030 A bench SHALL cover: fixed priority, LSB_HIGH_PRIORITY=0, request=8'b00110000 -> grant_encoded=5; ack -> 5 again.
REQ-031 A bench SHALL cover: BLOCK="REQUEST", granted port 2 drops request while port 6 is requesting -> next edge grant=8'b01000000.
REQ-032 A bench SHALL cover: acknowledge=8'b10000000 while port 3 is granted -> grant unchanged; reset pulse mid-grant -> grant=0 asynchronously; after release, request=8'b11111111 -> port 0 granted first.
REQ-033 A bench SHALL cover: every cycle of a random 2000-cycle run -> grant has $countones<=1, grant_encoded matches grant, no grant without a corresponding request at arbitration time.
